// File: rtl/mnist_pkg.sv
// -----------------------------------------------------------------------------
// mnist_pkg
// Shared definitions for the MNIST inference pipeline stages.
//   DATA_WIDTH_DEFAULT : default node word width (two's complement fixed point)
//   RELU_MAX_W         : widest word the relu helper accepts
//   state_t            : serializer FSM states (IDLE, STREAM)
//   relu()             : zeroes a negative word; the word width is given by the
//                        position of its sign bit, so one function serves every
//                        stage regardless of its word width
// -----------------------------------------------------------------------------
package mnist_pkg;

   localparam int DATA_WIDTH_DEFAULT = 24;
   localparam int RELU_MAX_W         = 64;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   // Callers zero-extend their word into x and pass the index of their own
   // sign bit; the result is truncated back to the caller's width.
   function automatic logic [RELU_MAX_W-1:0] relu(
      input logic [RELU_MAX_W-1:0] x,
      input logic [5:0]            sign_pos
   );
      relu = x[sign_pos] ? '0 : x;
   endfunction

endpackage

// File: rtl/layer_serializer.sv
// -----------------------------------------------------------------------------
// layer_serializer
// Captures the parallel node vector of a linear layer (one-cycle i_valid pulse)
// into a buffer, optionally applying ReLU, and replays it one word per cycle
// with a valid/ready handshake so it can feed the next layer or the argmax.
//
// Ports:
//   clk       : clock
//   rst       : asynchronous active-low reset
//   i_valid   : one-cycle pulse, din holds a complete vector
//   din       : NUM_NODES x DATA_WIDTH node vector
//   i_ready   : a vector presented this cycle will be captured
//   o_valid   : dout / o_index / o_last are valid
//   o_ready   : downstream accepts the current word
//   dout      : current stream word
//   o_index   : index of the current word, 0..NUM_NODES-1
//   o_last    : current word is the final word of the vector
//   drop_err  : sticky, a vector arrived while i_ready was low
// -----------------------------------------------------------------------------
module layer_serializer
   import mnist_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
   parameter int NUM_NODES  = 500,
   parameter bit RELU_EN    = 1'b1,
   localparam int IDX_W     = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_valid,
   input  logic [DATA_WIDTH-1:0] din [NUM_NODES],
   output logic                  i_ready,
   output logic                  o_valid,
   input  logic                  o_ready,
   output logic [DATA_WIDTH-1:0] dout,
   output logic [IDX_W-1:0]      o_index,
   output logic                  o_last,
   output logic                  drop_err
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

   state_t                  state_reg, state_next;
   logic [IDX_W-1:0]        idx_reg, idx_next;
   logic                    drop_reg, drop_next;
   logic                    capture;
   logic                    at_last;

   logic [DATA_WIDTH-1:0]   buffer [NUM_NODES];
   logic [DATA_WIDTH-1:0]   act_din [NUM_NODES];

   // Activation applied per node on the way into the buffer.
   generate
      for (genvar gi = 0; gi < NUM_NODES; gi++) begin : g_act
         if (RELU_EN) begin : g_relu
            assign act_din[gi] = DATA_WIDTH'(relu(RELU_MAX_W'(din[gi]), 6'(DATA_WIDTH - 1)));
         end else begin : g_pass
            assign act_din[gi] = din[gi];
         end
      end
   endgenerate

   assign at_last = (idx_reg == LAST_IDX);

   // Next-state logic. A vector is accepted either when idle or in the very
   // cycle the final word leaves, which lets vectors run back-to-back.
   always_comb begin
      i_ready    = (state_reg == IDLE) || ((state_reg == STREAM) && o_ready && at_last);
      capture    = i_valid && i_ready;
      state_next = state_reg;
      idx_next   = idx_reg;
      drop_next  = drop_reg || (i_valid && !i_ready);

      if (capture) begin
         state_next = STREAM;
         idx_next   = '0;
      end else if ((state_reg == STREAM) && o_ready) begin
         if (at_last) begin
            state_next = IDLE;
            idx_next   = '0;
         end else begin
            idx_next   = idx_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         drop_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         drop_reg  <= drop_next;
      end
   end

   // Buffer contents are meaningless until the first capture, so no reset.
   always_ff @(posedge clk) begin
      if (capture) begin
         for (int k = 0; k < NUM_NODES; k++) begin
            buffer[k] <= act_din[k];
         end
      end
   end

   // Outputs come only from state registers and the register-indexed buffer;
   // dout is forced to zero while idle so it is defined out of reset.
   assign o_valid  = (state_reg == STREAM);
   assign o_index  = idx_reg;
   assign o_last   = o_valid && at_last;
   assign dout     = o_valid ? buffer[idx_reg] : '0;
   assign drop_err = drop_reg;

endmodule

// File: tb/tb_layer_serializer.sv
module tb_layer_serializer;

   localparam int DW = 8;
   localparam int NN = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_valid;
   logic          o_ready;
   logic [DW-1:0] din [NN];

   // ReLU instance (a) and pass-through instance (b) share all inputs.
   logic          i_ready_a, o_valid_a, o_last_a, drop_err_a;
   logic [DW-1:0] dout_a;
   logic [1:0]    o_index_a;
   logic          i_ready_b, o_valid_b, o_last_b, drop_err_b;
   logic [DW-1:0] dout_b;
   logic [1:0]    o_index_b;

   always #5 clk = ~clk;

   layer_serializer #(.DATA_WIDTH(DW), .NUM_NODES(NN), .RELU_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .din(din), .i_ready(i_ready_a),
      .o_valid(o_valid_a), .o_ready(o_ready), .dout(dout_a), .o_index(o_index_a),
      .o_last(o_last_a), .drop_err(drop_err_a)
   );

   layer_serializer #(.DATA_WIDTH(DW), .NUM_NODES(NN), .RELU_EN(1'b0)) dut_raw (
      .clk(clk), .rst(rst), .i_valid(i_valid), .din(din), .i_ready(i_ready_b),
      .o_valid(o_valid_b), .o_ready(o_ready), .dout(dout_b), .o_index(o_index_b),
      .o_last(o_last_b), .drop_err(drop_err_b)
   );

   typedef struct {
      logic [DW-1:0] din;
      logic [DW-1:0] relu;
      logic [DW-1:0] raw;
   } word_vec_t;

   typedef struct {
      logic [DW-1:0] relu;
      logic [DW-1:0] raw;
      logic [1:0]    index;
      logic          last;
   } exp_t;

   word_vec_t tbl [12];
   exp_t      sbq [$];
   exp_t      mon_e;
   int        tests_run    = 0;
   int        tests_failed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard consumer: every accepted word is compared with the queue head.
   always @(negedge clk) begin
      if (rst && o_valid_a && o_ready) begin
         if (sbq.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_word: got index %0d, required no word", o_index_a);
         end else begin
            mon_e = sbq.pop_front();
            check("dout_relu", 32'(dout_a), 32'(mon_e.relu));
            check("dout_raw",  32'(dout_b), 32'(mon_e.raw));
            check("o_index",   32'(o_index_a), 32'(mon_e.index));
            check("o_last",    32'(o_last_a), 32'(mon_e.last));
            check("o_valid_raw", 32'(o_valid_b), 32'd1);
            $display("[TB] xfer idx=%0d dout=%02h raw=%02h last=%0b",
                     o_index_a, dout_a, dout_b, o_last_a);
         end
      end
   end

   // Called at posedge+1; i_valid is sampled by the following edge.
   task automatic send_vector(input int v, input bit expect_capture);
      for (int k = 0; k < NN; k++) begin
         din[k] = tbl[v*NN + k].din;
         if (expect_capture)
            sbq.push_back('{relu: tbl[v*NN + k].relu, raw: tbl[v*NN + k].raw,
                            index: 2'(k), last: (k == NN - 1)});
      end
      i_valid = 1'b1;
      @(posedge clk);
      #1 i_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sbq.size() != 0 && n < 40) begin
         @(posedge clk);
         n++;
      end
      if (sbq.size() != 0) begin
         tests_run++;
         tests_failed++;
         $display("FAIL %s_timeout: got %0d words pending, required 0", name, sbq.size());
         sbq.delete();
      end
      #1;
   endtask

   task automatic check_idle(input string name);
      check({name, "_o_valid"}, 32'(o_valid_a), 32'd0);
      check({name, "_i_ready"}, 32'(i_ready_a), 32'd1);
      check({name, "_o_last"},  32'(o_last_a),  32'd0);
   endtask

   initial begin
      tbl[0]  = '{8'h05, 8'h05, 8'h05};
      tbl[1]  = '{8'hFD, 8'h00, 8'hFD};
      tbl[2]  = '{8'h07, 8'h07, 8'h07};
      tbl[3]  = '{8'h80, 8'h00, 8'h80};
      tbl[4]  = '{8'h7F, 8'h7F, 8'h7F};
      tbl[5]  = '{8'hFF, 8'h00, 8'hFF};
      tbl[6]  = '{8'h00, 8'h00, 8'h00};
      tbl[7]  = '{8'h01, 8'h01, 8'h01};
      tbl[8]  = '{8'h81, 8'h00, 8'h81};
      tbl[9]  = '{8'h40, 8'h40, 8'h40};
      tbl[10] = '{8'hC0, 8'h00, 8'hC0};
      tbl[11] = '{8'h2A, 8'h2A, 8'h2A};

      rst     = 1'b0;
      i_valid = 1'b0;
      o_ready = 1'b1;
      for (int k = 0; k < NN; k++) din[k] = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_o_valid",  32'(o_valid_a),  32'd0);
      check("rst_o_last",   32'(o_last_a),   32'd0);
      check("rst_dout",     32'(dout_a),     32'd0);
      check("rst_drop_err", 32'(drop_err_a), 32'd0);
      check("rst_i_ready",  32'(i_ready_a),  32'd1);
      check("rst_o_index",  32'(o_index_a),  32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Table-driven vectors, each streamed to completion
      for (int v = 0; v < 3; v++) begin
         send_vector(v, 1'b1);
         check("first_word_valid", 32'(o_valid_a), 32'd1);
         drain("vec");
         check_idle("after_vec");
      end

      // Backpressure: hold o_ready low while index 1 is presented
      send_vector(0, 1'b1);
      @(posedge clk);
      #1 o_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("stall_o_valid", 32'(o_valid_a), 32'd1);
         check("stall_o_index", 32'(o_index_a), 32'd1);
         check("stall_dout",    32'(dout_a),    32'h00);
         check("stall_raw",     32'(dout_b),    32'hFD);
         check("stall_o_last",  32'(o_last_a),  32'd0);
         check("stall_i_ready", 32'(i_ready_a), 32'd0);
      end
      @(posedge clk);
      #1 o_ready = 1'b1;
      drain("stall");
      check_idle("after_stall");

      // Back-to-back: new vector offered in the last-word transfer cycle
      send_vector(1, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      check("b2b_o_index", 32'(o_index_a), 32'd3);
      check("b2b_i_ready", 32'(i_ready_a), 32'd1);
      send_vector(2, 1'b1);
      @(negedge clk);
      check("b2b_no_bubble_valid", 32'(o_valid_a), 32'd1);
      check("b2b_no_bubble_index", 32'(o_index_a), 32'd0);
      @(posedge clk);
      #1;
      drain("b2b");
      check("b2b_drop_err", 32'(drop_err_a), 32'd0);
      check_idle("after_b2b");

      // Overflow: vector offered mid-stream is dropped, stream unaffected
      send_vector(0, 1'b1);
      @(posedge clk);
      #1;
      check("ovf_i_ready", 32'(i_ready_a), 32'd0);
      check("ovf_drop_before", 32'(drop_err_a), 32'd0);
      send_vector(2, 1'b0);
      check("ovf_drop_err", 32'(drop_err_a), 32'd1);
      check("ovf_drop_err_raw", 32'(drop_err_b), 32'd1);
      drain("ovf");
      repeat (3) @(posedge clk);
      #1;
      check("ovf_drop_sticky", 32'(drop_err_a), 32'd1);
      check_idle("after_ovf");

      // Asynchronous reset mid-stream at index 2
      send_vector(2, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      check("mid_o_index", 32'(o_index_a), 32'd2);
      rst = 1'b0;
      #1;
      check("arst_o_valid",  32'(o_valid_a),  32'd0);
      check("arst_o_last",   32'(o_last_a),   32'd0);
      check("arst_dout",     32'(dout_a),     32'd0);
      check("arst_drop_err", 32'(drop_err_a), 32'd0);
      sbq.delete();
      @(posedge clk);
      #1 rst = 1'b1;
      check("post_rst_i_ready", 32'(i_ready_a), 32'd1);
      send_vector(1, 1'b1);
      @(negedge clk);
      check("post_rst_valid", 32'(o_valid_a), 32'd1);
      check("post_rst_index", 32'(o_index_a), 32'd0);
      @(posedge clk);
      #1;
      drain("post_rst");
      check_idle("after_post_rst");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
